bus_condition_gen: RTL and testbench
====================================

Name: bus_condition_gen

Overview:
- Controller-side generator of I3C/I2C bus conditions: START, Repeated START, STOP and the HDR Exit Pattern.
- Drives open-drain SCL/SDA enables with programmable setup, hold, rise and fall timing.
- Transmit-side counterpart of the target bus monitor.
- Sits between the controller FSM (command handshake) and the PHY open-drain drivers.

Parameters:
- CntW, 20, width of timing inputs and internal timing counter.
- HdrExitEdges, 4, number of SDA falling edges in the HDR Exit Pattern.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- enable_i  input  1  block enable; low aborts any sequence
- cmd_valid_i  input  1  command request
- cmd_i  input  2  bus_cond_e: START=0, RSTART=1, STOP=2, HDR_EXIT=3
- cmd_ready_o  output  1  command accepted when valid&&ready
- done_o  output  1  one-cycle pulse when the sequence completes
- err_o  output  1  one-cycle pulse when a command is illegal or the bus is not idle
- scl_i / sda_i  input  1 each  synchronized bus lines
- scl_o / sda_o  output  1 each  drive value: 0 = pull low, 1 = release
- t_hd_sta_i, t_su_sta_i, t_su_sto_i, t_r_i, t_f_i, t_hdr_tgl_i  input  CntW each  timings in clk cycles
- bus_owned_o  output  1  controller holds the bus (between START and STOP)

Behaviour:
- Reset values: scl_o=1, sda_o=1, done_o=0, err_o=0, bus_owned_o=0, state=IDLE.
- cmd_ready_o = (state==IDLE) & enable_i, combinational.
- All other outputs are registered.
- Timed states apply their line pattern on entry and hold it for N=max(t,1) cycles. The counter loads 1 on entry and exits when cnt>=N.
- Comparison is at CntW width with no wrap; the counter saturates.
- START:
  - Legal only if !bus_owned_o & scl_i & sda_i at accept; otherwise err_o pulses next cycle and the state stays IDLE.
  - Sequence: STA_HOLD (sda_o=0, t_hd_sta) -> SCL_FALL (scl_o=0, t_f) -> IDLE with done_o=1.
  - bus_owned_o sets on entry to SCL_FALL.
- RSTART: requires bus_owned_o, else err_o.
  - RS_SDA_REL (sda_o=1, t_r)
  - -> RS_SCL_REL (scl_o=1): wait untimed until scl_i==1 (clock stretch)
  - -> RS_SETUP (t_su_sta)
  - -> STA_HOLD -> SCL_FALL -> IDLE with done_o.
- STOP: requires bus_owned_o, else err_o.
  - STO_SDA_LOW (sda_o=0, t_f)
  - -> STO_SCL_REL (scl_o=1): wait for scl_i==1
  - -> STO_SETUP (t_su_sto)
  - -> STO_SDA_REL (sda_o=1, t_r)
  - -> IDLE with done_o. bus_owned_o clears on entry to STO_SDA_REL.
- HDR_EXIT: requires bus_owned_o, else err_o.
  - Holds scl_o=0 throughout the toggle phase.
  - Alternates HDR_SDA_HIGH (sda_o=1, t_hdr_tgl) and HDR_SDA_LOW (sda_o=0, t_hdr_tgl).
  - The edge counter increments on each HIGH->LOW transition.
  - After HdrExitEdges falling edges, enter STO_SCL_REL with sda_o=0, then continue as STOP. A single done_o pulses at the end.
- Clock stretch: wait states have no timeout; timeouts are handled by a higher layer.
- enable_i low in any non-IDLE state: next cycle state=IDLE, scl_o=1, sda_o=1, bus_owned_o=0, no done_o, no err_o.
- Reset mid-sequence: same as the enable abort, asynchronously.
- cmd_valid_i while not ready is ignored. cmd_i is sampled only on accept.
- done_o and err_o are never high in the same cycle.

Decomposition:
- controller_pkg additions: the bus_cond_e enum, the state enum bus_cond_state_e, and the default HDR_EXIT_EDGES=4.
- One sub-module: bus_timer.
  - Inputs: load, N (CntW).
  - Output: expired.
  - Saturating counter, shared by all timed states.

Test Plan:
- START with bus idle, t_hd_sta=5, t_f=2, accept at cycle 0 -> sda_o=0 at cycles 1-7; scl_o=0 from cycle 6; done_o=1 at cycle 8; bus_owned_o=1.
- RSTART with scl_i held low 10 extra cycles after scl_o release, t_su_sta=3 -> sda_o stays 1 until 3 cycles after scl_i rises; then START sequence completes; single done_o.
- STOP with t_f=1, t_su_sto=4, t_r=2 -> SDA low before SCL release; SDA rises 4 cycles after scl_i high; done_o 2 cycles later; bus_owned_o=0.
- HDR_EXIT, t_hdr_tgl=2 -> exactly 4 sda_o falling edges with scl_o=0; then STOP; the target bus monitor flags hdr_exit_detect in loopback.
- Illegal: STOP when not owned, or START with sda_i=0 -> err_o single pulse; lines stay released; cmd_ready_o high next cycle.
- Abort: enable_i low during RS_SETUP -> next cycle scl_o=sda_o=1, IDLE, no done_o; async rst_i mid-HDR_EXIT -> reset values immediately.

Source files
------------

// File: rtl/bus_condition_gen_pkg.sv
// Shared types for the controller-side bus condition generator.
package bus_condition_gen_pkg;

  localparam int unsigned HDR_EXIT_EDGES = 4;

  typedef enum logic [1:0] {
    BC_START    = 2'd0,
    BC_RSTART   = 2'd1,
    BC_STOP     = 2'd2,
    BC_HDR_EXIT = 2'd3
  } bus_cond_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STA_HOLD,
    S_SCL_FALL,
    S_RS_SDA_REL,
    S_RS_SCL_REL,
    S_RS_SETUP,
    S_STO_SDA_LOW,
    S_STO_SCL_REL,
    S_STO_SETUP,
    S_STO_SDA_REL,
    S_HDR_SDA_HIGH,
    S_HDR_SDA_LOW
  } bus_cond_state_e;

endpackage

// File: rtl/bus_condition_gen_timer.sv
// Saturating cycle counter shared by all timed bus-condition states.
module bus_timer #(
  parameter int unsigned CntW = 20
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] n_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] n_eff;

  // A zero timing still holds the pattern for one cycle.
  assign n_eff     = (n_i == '0) ? CntW'(1) : n_i;
  assign expired_o = (cnt_q >= n_eff);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CntW'(1);
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/bus_condition_gen.sv
// Generates START / Repeated START / STOP / HDR Exit on open-drain SCL/SDA.
module bus_condition_gen
  import bus_condition_gen_pkg::*;
#(
  parameter int unsigned CntW         = 20,
  parameter int unsigned HdrExitEdges = HDR_EXIT_EDGES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            cmd_valid_i,
  input  logic [1:0]      cmd_i,
  output logic            cmd_ready_o,
  output logic            done_o,
  output logic            err_o,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            scl_o,
  output logic            sda_o,
  input  logic [CntW-1:0] t_hd_sta_i,
  input  logic [CntW-1:0] t_su_sta_i,
  input  logic [CntW-1:0] t_su_sto_i,
  input  logic [CntW-1:0] t_r_i,
  input  logic [CntW-1:0] t_f_i,
  input  logic [CntW-1:0] t_hdr_tgl_i,
  output logic            bus_owned_o
);

  localparam int unsigned EdgeW = $clog2(HdrExitEdges + 1);

  bus_cond_state_e state_q, state_d;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic scl_d, sda_d, owned_d, done_d, err_d;
  logic [CntW-1:0] tmr_n;
  logic tmr_load, tmr_expired;

  assign cmd_ready_o = (state_q == S_IDLE) & enable_i;
  assign tmr_load    = (state_d != state_q);

  bus_timer #(.CntW(CntW)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .n_i       (tmr_n),
    .expired_o (tmr_expired)
  );

  always_comb begin
    tmr_n = '0;
    case (state_q)
      S_STA_HOLD:                     tmr_n = t_hd_sta_i;
      S_SCL_FALL, S_STO_SDA_LOW:      tmr_n = t_f_i;
      S_RS_SDA_REL, S_STO_SDA_REL:    tmr_n = t_r_i;
      S_RS_SETUP:                     tmr_n = t_su_sta_i;
      S_STO_SETUP:                    tmr_n = t_su_sto_i;
      S_HDR_SDA_HIGH, S_HDR_SDA_LOW:  tmr_n = t_hdr_tgl_i;
      default:                        tmr_n = '0;
    endcase
  end

  // Line values are computed for the next state so they change on state entry.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    scl_d   = scl_o;
    sda_d   = sda_o;
    owned_d = bus_owned_o;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if ((state_q != S_IDLE) && !enable_i) begin
      state_d = S_IDLE;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      owned_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            case (bus_cond_e'(cmd_i))
              BC_START: begin
                if (!bus_owned_o && scl_i && sda_i) begin
                  state_d = S_STA_HOLD;
                  sda_d   = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              BC_RSTART: begin
                if (bus_owned_o) begin
                  state_d = S_RS_SDA_REL;
                  sda_d   = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              BC_STOP: begin
                if (bus_owned_o) begin
                  state_d = S_STO_SDA_LOW;
                  sda_d   = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: begin
                if (bus_owned_o) begin
                  state_d = S_HDR_SDA_HIGH;
                  scl_d   = 1'b0;
                  sda_d   = 1'b1;
                  edge_d  = '0;
                end else begin
                  err_d = 1'b1;
                end
              end
            endcase
          end
        end
        S_STA_HOLD: if (tmr_expired) begin
          state_d = S_SCL_FALL;
          scl_d   = 1'b0;
          owned_d = 1'b1;
        end
        S_SCL_FALL: if (tmr_expired) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        S_RS_SDA_REL: if (tmr_expired) begin
          state_d = S_RS_SCL_REL;
          scl_d   = 1'b1;
        end
        S_RS_SCL_REL: if (scl_i) state_d = S_RS_SETUP;
        S_RS_SETUP: if (tmr_expired) begin
          state_d = S_STA_HOLD;
          sda_d   = 1'b0;
        end
        S_STO_SDA_LOW: if (tmr_expired) begin
          state_d = S_STO_SCL_REL;
          scl_d   = 1'b1;
        end
        S_STO_SCL_REL: if (scl_i) state_d = S_STO_SETUP;
        S_STO_SETUP: if (tmr_expired) begin
          state_d = S_STO_SDA_REL;
          sda_d   = 1'b1;
          owned_d = 1'b0;
        end
        S_STO_SDA_REL: if (tmr_expired) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        S_HDR_SDA_HIGH: if (tmr_expired) begin
          state_d = S_HDR_SDA_LOW;
          sda_d   = 1'b0;
          edge_d  = edge_q + EdgeW'(1);
        end
        S_HDR_SDA_LOW: if (tmr_expired) begin
          // SDA is already low here, so the STOP tail starts at SCL release.
          if (edge_q == EdgeW'(HdrExitEdges)) begin
            state_d = S_STO_SCL_REL;
            scl_d   = 1'b1;
          end else begin
            state_d = S_HDR_SDA_HIGH;
            sda_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
          owned_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      edge_q      <= '0;
      scl_o       <= 1'b1;
      sda_o       <= 1'b1;
      bus_owned_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      scl_o       <= scl_d;
      sda_o       <= sda_d;
      bus_owned_o <= owned_d;
      done_o      <= done_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_condition_gen.sv
// Directed bench for bus_condition_gen with open-drain loopback on SCL/SDA.
module tb_bus_condition_gen;
  import bus_condition_gen_pkg::*;

  localparam int unsigned CW = 20;

  logic clk = 1'b0;
  logic rst, enable, cmd_valid;
  logic [1:0] cmd;
  logic cmd_ready, done, err, scl_in, sda_in, scl_out, sda_out, owned;
  logic [CW-1:0] t_hd_sta, t_su_sta, t_su_sto, t_r, t_f, t_hdr_tgl;
  logic scl_low, sda_low;

  int n_chk = 0;
  int n_fail = 0;

  assign scl_in = scl_out & ~scl_low;
  assign sda_in = sda_out & ~sda_low;

  always #5 clk = ~clk;

  bus_condition_gen #(.CntW(CW), .HdrExitEdges(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .cmd_valid_i(cmd_valid), .cmd_i(cmd), .cmd_ready_o(cmd_ready),
    .done_o(done), .err_o(err),
    .scl_i(scl_in), .sda_i(sda_in), .scl_o(scl_out), .sda_o(sda_out),
    .t_hd_sta_i(t_hd_sta), .t_su_sta_i(t_su_sta), .t_su_sto_i(t_su_sto),
    .t_r_i(t_r), .t_f_i(t_f), .t_hdr_tgl_i(t_hdr_tgl),
    .bus_owned_o(owned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bus_cond_e c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic lines(input string tag, input logic s, input logic d,
                       input logic dn, input logic own);
    chk({tag, ".scl"},   32'(scl_out), 32'(s));
    chk({tag, ".sda"},   32'(sda_out), 32'(d));
    chk({tag, ".done"},  32'(done),    32'(dn));
    chk({tag, ".owned"}, 32'(owned),   32'(own));
  endtask

  task automatic do_start();
    t_hd_sta = 1;
    t_f      = 1;
    issue(BC_START);
    tick();
    tick();
    chk("quick_start.done", 32'(done), 32'd1);
    chk("quick_start.owned", 32'(owned), 32'd1);
  endtask

  initial begin
    int falls, dones, done_at, errs, stops;
    logic prev_sda;

    rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd = 2'd0;
    scl_low = 1'b0; sda_low = 1'b0;
    t_hd_sta = 1; t_su_sta = 1; t_su_sto = 1; t_r = 1; t_f = 1; t_hdr_tgl = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    lines("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.ready", 32'(cmd_ready), 32'd1);
    tick();

    // START: t_hd_sta=5, t_f=2
    t_hd_sta = 5; t_f = 2;
    issue(BC_START);
    for (int c = 1; c <= 9; c++) begin
      lines($sformatf("start.c%0d", c), c < 6, 1'b0, c == 8, c >= 6);
      chk($sformatf("start.ready.c%0d", c), 32'(cmd_ready), 32'(c >= 8));
      tick();
    end

    // RSTART with 10 cycles of clock stretch
    t_r = 2; t_su_sta = 3; t_hd_sta = 2; t_f = 1; scl_low = 1'b1;
    issue(BC_RSTART);
    for (int c = 1; c <= 21; c++) begin
      if (c == 13) begin
        scl_low = 1'b0;
        #0;
      end
      lines($sformatf("rstart.c%0d", c), (c >= 3) && (c <= 18), c <= 16, c == 20, 1'b1);
      chk($sformatf("rstart.err.c%0d", c), 32'(err), 32'd0);
      tick();
    end

    // STOP: t_f=1, t_su_sto=4, t_r=2
    t_f = 1; t_su_sto = 4; t_r = 2;
    issue(BC_STOP);
    for (int c = 1; c <= 10; c++) begin
      lines($sformatf("stop.c%0d", c), c >= 2, c >= 7, c == 9, c < 7);
      tick();
    end

    // Illegal commands
    issue(BC_STOP);
    chk("stop_unowned.err", 32'(err), 32'd1);
    lines("stop_unowned", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stop_unowned.ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("stop_unowned.err_pulse", 32'(err), 32'd0);
    sda_low = 1'b1;
    issue(BC_START);
    chk("start_sda_low.err", 32'(err), 32'd1);
    lines("start_sda_low", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_sda_low.ready", 32'(cmd_ready), 32'd1);
    sda_low = 1'b0;
    tick();
    chk("start_sda_low.err_pulse", 32'(err), 32'd0);
    issue(BC_HDR_EXIT);
    chk("hdr_unowned.err", 32'(err), 32'd1);
    tick();

    // HDR exit pattern followed by STOP
    do_start();
    t_hdr_tgl = 2; t_su_sto = 1; t_r = 1;
    prev_sda = sda_out;
    falls = 0; dones = 0; done_at = 0; errs = 0; stops = 0;
    issue(BC_HDR_EXIT);
    for (int c = 1; c <= 24; c++) begin
      if (prev_sda && !sda_out && !scl_out) falls++;
      if (!prev_sda && sda_out && scl_out) stops++;
      if (done) begin
        dones++;
        done_at = c;
      end
      if (err) errs++;
      if (c <= 16) chk($sformatf("hdr.scl_low.c%0d", c), 32'(scl_out), 32'd0);
      prev_sda = sda_out;
      tick();
    end
    chk("hdr.falls", 32'(falls), 32'd4);
    chk("hdr.stops", 32'(stops), 32'd1);
    chk("hdr.dones", 32'(dones), 32'd1);
    chk("hdr.done_at", 32'(done_at), 32'd20);
    chk("hdr.errs", 32'(errs), 32'd0);
    lines("hdr.end", 1'b1, 1'b1, 1'b0, 1'b0);

    // enable_i low during RS_SETUP
    do_start();
    t_r = 1; t_su_sta = 5;
    issue(BC_RSTART);
    tick();
    tick();
    lines("abort.setup", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort.ready_busy", 32'(cmd_ready), 32'd0);
    tick();
    enable = 1'b0;
    tick();
    lines("abort.after", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort.err", 32'(err), 32'd0);
    chk("abort.ready_disabled", 32'(cmd_ready), 32'd0);
    enable = 1'b1;
    #1;
    chk("abort.ready_enabled", 32'(cmd_ready), 32'd1);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) dones++;
    end
    chk("abort.no_done", 32'(dones), 32'd0);

    // Asynchronous reset in the middle of the HDR toggle phase
    do_start();
    t_hdr_tgl = 3;
    issue(BC_HDR_EXIT);
    tick();
    tick();
    tick();
    lines("rst_mid.before", 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    lines("rst_mid.async", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_mid.err", 32'(err), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("rst_mid.ready", 32'(cmd_ready), 32'd1);
    lines("rst_mid.after", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
